hsn_block_sync: RTL and testbench

Parametrised block-synchroniser for the Aurora 64b/66b receive path, replacing the fixed hierarchical seeker tree.
- Searches for the 2-bit sync-header position in each gearbox buffer using N_SEEKERS parallel seekers, and qualifies a position after LOCK_CNT consecutive good headers.
- Adds what the fixed tree lacks: hold-while-locked, windowed loss-of-lock detection, forced resync, and a registered header output for the downstream descrambler/frame decoder.

---
 rtl/hsn_block_sync_if.sv | 26 ++
 rtl/hsn_block_sync.sv | 160 ++++++++++++++++
 tb/tb_hsn_block_sync.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hsn_block_sync_if.sv
// Receive-side bus of the block synchroniser: gearbox buffer and resync request in,
// lock status and the registered header stream out.
interface hsn_block_sync_if #(
    parameter int FRAME_W = 66,
    parameter int POS_W   = $clog2(FRAME_W)
);
    logic             buffer_dv;
    logic [FRAME_W:0] buffer;
    logic             resync_i;
    logic             is_synced;
    logic [POS_W-1:0] offset_pos;
    logic             lock_lost_o;
    logic [1:0]       hdr_o;
    logic             hdr_dv_o;
    logic             hdr_err_o;

    modport master (
        output buffer_dv, buffer, resync_i,
        input  is_synced, offset_pos, lock_lost_o, hdr_o, hdr_dv_o, hdr_err_o
    );

    modport slave (
        input  buffer_dv, buffer, resync_i,
        output is_synced, offset_pos, lock_lost_o, hdr_o, hdr_dv_o, hdr_err_o
    );
endinterface

// File: rtl/hsn_block_sync.sv
// Aurora 64b/66b block synchroniser: parallel sync-header seekers, a windowed lock monitor
// with forced resync, and a registered header output for the descrambler.
module hsn_block_sync #(
    parameter int FRAME_W   = 66,
    parameter int N_SEEKERS = 11,
    parameter int LOCK_CNT  = 32,
    parameter int WIN       = 64,
    parameter int MAX_BAD   = 16,
    parameter int POS_W     = $clog2(FRAME_W)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    hsn_block_sync_if.slave rx
);
    localparam int IDX_W = $clog2(FRAME_W + 1);
    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W = $clog2(WIN + 1);
    localparam int BAD_W = $clog2(MAX_BAD + 1);

    typedef enum logic {SEARCH, LOCKED} state_e;

    state_e           state_q, state_d;
    logic [POS_W-1:0] seekPos_q [N_SEEKERS];
    logic [POS_W-1:0] seekPos_d [N_SEEKERS];
    logic [CNT_W-1:0] seekCnt_q [N_SEEKERS];
    logic [CNT_W-1:0] seekCnt_d [N_SEEKERS];
    logic [WIN_W-1:0] winCnt_q, winCnt_d;
    logic [BAD_W-1:0] badCnt_q, badCnt_d;
    logic [POS_W-1:0] offset_q, offset_d;
    logic             lockLost_q, lockLost_d;
    logic [1:0]       hdr_q, hdr_d;
    logic             hdrDv_q, hdrDv_d;
    logic             hdrErr_q, hdrErr_d;

    logic [IDX_W-1:0] lockIdx;
    logic             lockBad;
    logic [IDX_W-1:0] seekIdx;
    logic             seekGood;
    logic [POS_W:0]   stepPos;
    logic             found;
    logic [POS_W-1:0] winnerPos;
    logic             restart;

    assign lockIdx = IDX_W'(offset_q);
    assign lockBad = ~(rx.buffer[lockIdx] ^ rx.buffer[lockIdx + IDX_W'(1)]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= SEARCH;
            for (int k = 0; k < N_SEEKERS; k++) begin
                seekPos_q[k] <= POS_W'(k);
                seekCnt_q[k] <= '0;
            end
            winCnt_q   <= '0;
            badCnt_q   <= '0;
            offset_q   <= '0;
            lockLost_q <= 1'b0;
            hdr_q      <= 2'b00;
            hdrDv_q    <= 1'b0;
            hdrErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            seekPos_q  <= seekPos_d;
            seekCnt_q  <= seekCnt_d;
            winCnt_q   <= winCnt_d;
            badCnt_q   <= badCnt_d;
            offset_q   <= offset_d;
            lockLost_q <= lockLost_d;
            hdr_q      <= hdr_d;
            hdrDv_q    <= hdrDv_d;
            hdrErr_q   <= hdrErr_d;
        end
    end

    // Seekers step by N_SEEKERS on a bad header so together they sweep every position;
    // the lowest-index seeker wins a tie because the scan keeps only the first hit.
    always_comb begin
        state_d    = state_q;
        seekPos_d  = seekPos_q;
        seekCnt_d  = seekCnt_q;
        winCnt_d   = winCnt_q;
        badCnt_d   = badCnt_q;
        offset_d   = offset_q;
        lockLost_d = 1'b0;
        hdr_d      = hdr_q;
        hdrDv_d    = 1'b0;
        hdrErr_d   = hdrErr_q;
        seekIdx    = '0;
        seekGood   = 1'b0;
        stepPos    = '0;
        found      = 1'b0;
        winnerPos  = '0;
        restart    = 1'b0;

        if (rx.resync_i) begin
            state_d    = SEARCH;
            restart    = 1'b1;
            lockLost_d = (state_q == LOCKED);
        end else if (rx.buffer_dv) begin
            if (state_q == SEARCH) begin
                for (int k = 0; k < N_SEEKERS; k++) begin
                    seekIdx  = IDX_W'(seekPos_q[k]);
                    seekGood = rx.buffer[seekIdx] ^ rx.buffer[seekIdx + IDX_W'(1)];
                    if (seekGood) begin
                        if (seekCnt_q[k] != CNT_W'(LOCK_CNT)) begin
                            seekCnt_d[k] = seekCnt_q[k] + CNT_W'(1);
                        end
                        if (!found && seekCnt_d[k] == CNT_W'(LOCK_CNT)) begin
                            found     = 1'b1;
                            winnerPos = seekPos_q[k];
                        end
                    end else begin
                        seekCnt_d[k] = '0;
                        stepPos      = {1'b0, seekPos_q[k]} + (POS_W+1)'(N_SEEKERS);
                        seekPos_d[k] = (stepPos > (POS_W+1)'(FRAME_W - 1)) ? POS_W'(k)
                                                                           : stepPos[POS_W-1:0];
                    end
                end
                if (found) begin
                    state_d  = LOCKED;
                    offset_d = winnerPos;
                    winCnt_d = '0;
                    badCnt_d = '0;
                end
            end else begin
                hdr_d    = {rx.buffer[lockIdx + IDX_W'(1)], rx.buffer[lockIdx]};
                hdrErr_d = lockBad;
                hdrDv_d  = 1'b1;
                winCnt_d = winCnt_q + WIN_W'(1);
                badCnt_d = badCnt_q + BAD_W'(lockBad);
                // Loss is checked before the window clear so the closing header still counts.
                if (badCnt_d == BAD_W'(MAX_BAD)) begin
                    state_d    = SEARCH;
                    lockLost_d = 1'b1;
                    restart    = 1'b1;
                end else if (winCnt_d == WIN_W'(WIN)) begin
                    winCnt_d = '0;
                    badCnt_d = '0;
                end
            end
        end

        if (restart) begin
            for (int k = 0; k < N_SEEKERS; k++) begin
                seekPos_d[k] = POS_W'(k);
                seekCnt_d[k] = '0;
            end
            offset_d = '0;
            winCnt_d = '0;
            badCnt_d = '0;
        end
    end

    assign rx.is_synced   = (state_q == LOCKED);
    assign rx.offset_pos  = offset_q;
    assign rx.lock_lost_o = lockLost_q;
    assign rx.hdr_o       = hdr_q;
    assign rx.hdr_dv_o    = hdrDv_q;
    assign rx.hdr_err_o   = hdrErr_q;
endmodule

// File: tb/tb_hsn_block_sync.sv
// Directed bench for hsn_block_sync: lock, tie-break, loss window, resync, dv gaps and reset.
module tb_hsn_block_sync;
    logic        clk;
    logic        rst;
    logic [66:0] buf23;
    logic [66:0] bufTie;
    logic [66:0] bufZero;
    int          cmpCount;
    int          errCount;

    hsn_block_sync_if #(.FRAME_W(66), .POS_W(7)) bus ();

    hsn_block_sync #(
        .FRAME_W(66), .N_SEEKERS(11), .LOCK_CNT(32), .WIN(64), .MAX_BAD(16), .POS_W(7)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .rx   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; inputs are consumed by the next posedge and results are
    // visible on return at the following negedge.
    task automatic applyStimulus(input logic dv, input logic [66:0] b);
        bus.buffer_dv = dv;
        bus.buffer    = b;
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, bufZero);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b1, buf23);
        applyStimulus(1'b1, buf23);
        cmpCount++; if (bus.is_synced !== 1'b0) begin errCount++; $display("[TB] FAIL reset.is_synced got %0b want 0", bus.is_synced); end
        cmpCount++; if (bus.offset_pos !== 7'd0) begin errCount++; $display("[TB] FAIL reset.offset_pos got %0d want 0", bus.offset_pos); end
        cmpCount++; if (bus.lock_lost_o !== 1'b0) begin errCount++; $display("[TB] FAIL reset.lock_lost got %0b want 0", bus.lock_lost_o); end
        cmpCount++; if (bus.hdr_o !== 2'b00) begin errCount++; $display("[TB] FAIL reset.hdr_o got %b want 00", bus.hdr_o); end
        cmpCount++; if (bus.hdr_dv_o !== 1'b0) begin errCount++; $display("[TB] FAIL reset.hdr_dv got %0b want 0", bus.hdr_dv_o); end
        cmpCount++; if (bus.hdr_err_o !== 1'b0) begin errCount++; $display("[TB] FAIL reset.hdr_err got %0b want 0", bus.hdr_err_o); end
        rst = 1'b0;
    endtask

    task automatic test_single_lock();
        repeat (33) applyStimulus(1'b1, buf23);
        cmpCount++; if (bus.is_synced !== 1'b0) begin errCount++; $display("[TB] FAIL single.early_sync got %0b want 0", bus.is_synced); end
        applyStimulus(1'b1, buf23);
        cmpCount++; if (bus.is_synced !== 1'b1) begin errCount++; $display("[TB] FAIL single.is_synced got %0b want 1", bus.is_synced); end
        cmpCount++; if (bus.offset_pos !== 7'd23) begin errCount++; $display("[TB] FAIL single.offset_pos got %0d want 23", bus.offset_pos); end
        cmpCount++; if (bus.hdr_dv_o !== 1'b0) begin errCount++; $display("[TB] FAIL single.hdr_dv_at_lock got %0b want 0", bus.hdr_dv_o); end
        applyStimulus(1'b1, buf23);
        cmpCount++; if (bus.hdr_o !== 2'b10) begin errCount++; $display("[TB] FAIL single.hdr_o got %b want 10", bus.hdr_o); end
        cmpCount++; if (bus.hdr_dv_o !== 1'b1) begin errCount++; $display("[TB] FAIL single.hdr_dv got %0b want 1", bus.hdr_dv_o); end
        cmpCount++; if (bus.hdr_err_o !== 1'b0) begin errCount++; $display("[TB] FAIL single.hdr_err got %0b want 0", bus.hdr_err_o); end
    endtask

    // Entered locked with header 1 of the window already consumed.
    task automatic test_loss_threshold();
        repeat (15) applyStimulus(1'b1, bufZero);
        cmpCount++; if (bus.is_synced !== 1'b1) begin errCount++; $display("[TB] FAIL loss.keep15 got %0b want 1", bus.is_synced); end
        cmpCount++; if (bus.hdr_err_o !== 1'b1) begin errCount++; $display("[TB] FAIL loss.hdr_err got %0b want 1", bus.hdr_err_o); end
        cmpCount++; if (bus.hdr_o !== 2'b00) begin errCount++; $display("[TB] FAIL loss.hdr_bad got %b want 00", bus.hdr_o); end
        repeat (48) applyStimulus(1'b1, buf23);
        repeat (15) applyStimulus(1'b1, bufZero);
        cmpCount++; if (bus.is_synced !== 1'b1) begin errCount++; $display("[TB] FAIL loss.window_clear got %0b want 1", bus.is_synced); end
        repeat (49) applyStimulus(1'b1, buf23);
        repeat (15) applyStimulus(1'b1, bufZero);
        cmpCount++; if (bus.lock_lost_o !== 1'b0) begin errCount++; $display("[TB] FAIL loss.early_pulse got %0b want 0", bus.lock_lost_o); end
        applyStimulus(1'b1, bufZero);
        cmpCount++; if (bus.is_synced !== 1'b0) begin errCount++; $display("[TB] FAIL loss.is_synced got %0b want 0", bus.is_synced); end
        cmpCount++; if (bus.lock_lost_o !== 1'b1) begin errCount++; $display("[TB] FAIL loss.pulse got %0b want 1", bus.lock_lost_o); end
        cmpCount++; if (bus.offset_pos !== 7'd0) begin errCount++; $display("[TB] FAIL loss.offset_pos got %0d want 0", bus.offset_pos); end
        cmpCount++; if (bus.hdr_dv_o !== 1'b1 || bus.hdr_err_o !== 1'b1) begin errCount++; $display("[TB] FAIL loss.last_hdr got dv=%0b err=%0b want dv=1 err=1", bus.hdr_dv_o, bus.hdr_err_o); end
        applyStimulus(1'b1, buf23);
        cmpCount++; if (bus.lock_lost_o !== 1'b0) begin errCount++; $display("[TB] FAIL loss.pulse_width got %0b want 0", bus.lock_lost_o); end
        repeat (32) applyStimulus(1'b1, buf23);
        cmpCount++; if (bus.is_synced !== 1'b0) begin errCount++; $display("[TB] FAIL loss.relock_early got %0b want 0", bus.is_synced); end
        applyStimulus(1'b1, buf23);
        cmpCount++; if (bus.is_synced !== 1'b1 || bus.offset_pos !== 7'd23) begin errCount++; $display("[TB] FAIL loss.relock got sync=%0b pos=%0d want sync=1 pos=23", bus.is_synced, bus.offset_pos); end
    endtask

    // Entered locked.
    task automatic test_resync();
        bus.resync_i = 1'b1;
        applyStimulus(1'b1, buf23);
        bus.resync_i = 1'b0;
        cmpCount++; if (bus.lock_lost_o !== 1'b1) begin errCount++; $display("[TB] FAIL resync.pulse got %0b want 1", bus.lock_lost_o); end
        cmpCount++; if (bus.is_synced !== 1'b0) begin errCount++; $display("[TB] FAIL resync.is_synced got %0b want 0", bus.is_synced); end
        cmpCount++; if (bus.hdr_dv_o !== 1'b0) begin errCount++; $display("[TB] FAIL resync.hdr_dv got %0b want 0", bus.hdr_dv_o); end
        cmpCount++; if (bus.offset_pos !== 7'd0) begin errCount++; $display("[TB] FAIL resync.offset_pos got %0d want 0", bus.offset_pos); end
        applyStimulus(1'b0, bufZero);
        cmpCount++; if (bus.lock_lost_o !== 1'b0) begin errCount++; $display("[TB] FAIL resync.pulse_width got %0b want 0", bus.lock_lost_o); end
        repeat (10) applyStimulus(1'b1, buf23);
        bus.resync_i = 1'b1;
        applyStimulus(1'b1, buf23);
        bus.resync_i = 1'b0;
        cmpCount++; if (bus.lock_lost_o !== 1'b0) begin errCount++; $display("[TB] FAIL resync.search_pulse got %0b want 0", bus.lock_lost_o); end
        repeat (33) applyStimulus(1'b1, buf23);
        cmpCount++; if (bus.is_synced !== 1'b0) begin errCount++; $display("[TB] FAIL resync.restart_early got %0b want 0", bus.is_synced); end
        applyStimulus(1'b1, buf23);
        cmpCount++; if (bus.is_synced !== 1'b1) begin errCount++; $display("[TB] FAIL resync.relock got %0b want 1", bus.is_synced); end
    endtask

    task automatic test_tie();
        doReset();
        repeat (31) applyStimulus(1'b1, bufTie);
        cmpCount++; if (bus.is_synced !== 1'b0) begin errCount++; $display("[TB] FAIL tie.early got %0b want 0", bus.is_synced); end
        applyStimulus(1'b1, bufTie);
        cmpCount++; if (bus.is_synced !== 1'b1) begin errCount++; $display("[TB] FAIL tie.is_synced got %0b want 1", bus.is_synced); end
        cmpCount++; if (bus.offset_pos !== 7'd3) begin errCount++; $display("[TB] FAIL tie.offset_pos got %0d want 3", bus.offset_pos); end
    endtask

    // Gap beats carry an all-bad buffer that must be ignored.
    task automatic test_dv_gaps();
        doReset();
        for (int i = 0; i < 33; i++) begin
            applyStimulus(1'b1, buf23);
            applyStimulus(1'b0, bufZero);
        end
        cmpCount++; if (bus.is_synced !== 1'b0) begin errCount++; $display("[TB] FAIL gaps.early got %0b want 0", bus.is_synced); end
        applyStimulus(1'b1, buf23);
        cmpCount++; if (bus.is_synced !== 1'b1 || bus.offset_pos !== 7'd23) begin errCount++; $display("[TB] FAIL gaps.lock got sync=%0b pos=%0d want sync=1 pos=23", bus.is_synced, bus.offset_pos); end
        applyStimulus(1'b0, bufZero);
        cmpCount++; if (bus.is_synced !== 1'b1 || bus.hdr_dv_o !== 1'b0) begin errCount++; $display("[TB] FAIL gaps.hold got sync=%0b dv=%0b want sync=1 dv=0", bus.is_synced, bus.hdr_dv_o); end
    endtask

    task automatic test_reset_mid();
        doReset();
        repeat (20) applyStimulus(1'b1, buf23);
        rst = 1'b1;
        applyStimulus(1'b1, buf23);
        rst = 1'b0;
        cmpCount++; if (bus.is_synced !== 1'b0 || bus.offset_pos !== 7'd0) begin errCount++; $display("[TB] FAIL rstmid.search got sync=%0b pos=%0d want sync=0 pos=0", bus.is_synced, bus.offset_pos); end
        repeat (33) applyStimulus(1'b1, buf23);
        cmpCount++; if (bus.is_synced !== 1'b0) begin errCount++; $display("[TB] FAIL rstmid.early got %0b want 0", bus.is_synced); end
        applyStimulus(1'b1, buf23);
        cmpCount++; if (bus.is_synced !== 1'b1) begin errCount++; $display("[TB] FAIL rstmid.relock got %0b want 1", bus.is_synced); end
        applyStimulus(1'b1, buf23);
        rst = 1'b1;
        applyStimulus(1'b1, buf23);
        rst = 1'b0;
        cmpCount++; if (bus.is_synced !== 1'b0) begin errCount++; $display("[TB] FAIL rstlock.is_synced got %0b want 0", bus.is_synced); end
        cmpCount++; if (bus.hdr_o !== 2'b00 || bus.hdr_dv_o !== 1'b0 || bus.hdr_err_o !== 1'b0) begin errCount++; $display("[TB] FAIL rstlock.hdr got hdr=%b dv=%0b err=%0b want 00/0/0", bus.hdr_o, bus.hdr_dv_o, bus.hdr_err_o); end
        cmpCount++; if (bus.offset_pos !== 7'd0 || bus.lock_lost_o !== 1'b0) begin errCount++; $display("[TB] FAIL rstlock.offset got pos=%0d lost=%0b want 0/0", bus.offset_pos, bus.lock_lost_o); end
    endtask

    initial begin
        cmpCount      = 0;
        errCount      = 0;
        rst           = 1'b1;
        bus.buffer_dv = 1'b0;
        bus.resync_i  = 1'b0;
        bufZero       = '0;
        bus.buffer    = bufZero;
        buf23         = {{43{1'b1}}, 24'd0};
        bufTie        = 67'd16;
        @(negedge clk);
        test_reset();
        test_single_lock();
        test_loss_threshold();
        test_resync();
        test_tie();
        test_dv_gaps();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end
endmodule
